// File: rtl/msort_pkg.sv
// Shared types and default sizes for the sorter receive path (m_sort_drain, m_vec_fifo).
`default_nettype none

package msort_pkg;
    localparam int N_DEF     = 4;
    localparam int M_DEF     = 4;
    localparam int LAT_DEF   = 2 * M_DEF - 1;
    localparam int DEPTH_DEF = 4;
    localparam int IDX_W     = (M_DEF > 1) ? $clog2(M_DEF) : 1;
    localparam int CNT_W     = $clog2(DEPTH_DEF) + 1;

    typedef logic [N_DEF-1:0] elem_t;
    typedef elem_t [M_DEF-1:0] vec_t;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;
endpackage

`default_nettype wire

// File: rtl/m_vec_fifo.sv
// DEPTH x W synchronous vector FIFO; a push while full is accepted only if a pop frees the head slot.
`default_nettype none

module m_vec_fifo
    import msort_pkg::*;
#(
    parameter int W     = N_DEF * M_DEF,
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [W-1:0]             din,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic [W-1:0]             head
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            unique case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // When full, wr_ptr equals rd_ptr, so a push-with-pop overwrites the slot being retired.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end
endmodule

`default_nettype wire

// File: rtl/m_sort_drain.sv
// Sorter receive end: latency-matched valid chain, vector FIFO and element serializer.
// Optional MSORTDRAIN_ORDER_CHECK_EN builds the non-increasing order checker behind OrderErr.
`default_nettype none

module m_sort_drain
    import msort_pkg::*;
#(
    parameter int N     = N_DEF,
    parameter int M     = M_DEF,
    parameter int LAT   = 2 * M - 1,
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic                    Clk,
    input  logic                    Reset,
    input  logic                    InValid,
    input  logic [M-1:0][N-1:0]     Y,
    output logic [N-1:0]            OutData,
    output logic [$clog2(M)-1:0]    OutIdx,
    output logic                    OutValid,
    input  logic                    OutReady,
    output logic                    OutLast,
    output logic [$clog2(DEPTH):0]  Count,
    output logic                    Overflow,
    output logic                    OrderErr
);
    localparam int IW = $clog2(M);

    logic [LAT-1:0]         vchain;
    logic                   cap;
    logic                   full;
    logic                   empty;
    logic                   push_ok;
    logic                   hs;
    logic                   last_hs;
    logic                   more;
    logic [M-1:0][N-1:0]    head_v;
    logic [IW-1:0]          idx;
    logic [IW-1:0]          idx_nx;
    state_t                 state;
    state_t                 state_nx;
    logic                   overflow_r;

    if (LAT == 1) begin : g_chain_1
        always_ff @(posedge Clk) begin
            if (Reset) vchain <= '0;
            else       vchain <= InValid;
        end
    end else begin : g_chain_n
        always_ff @(posedge Clk) begin
            if (Reset) vchain <= '0;
            else       vchain <= {vchain[LAT-2:0], InValid};
        end
    end

    assign cap     = vchain[LAT-1];
    assign hs      = (state == SEND) & OutReady;
    assign last_hs = hs & (idx == IW'(M - 1));
    assign push_ok = cap & (~full | last_hs);
    // After retiring the head, another vector remains if one was queued behind it or arrives now.
    assign more    = (Count != ($clog2(DEPTH)+1)'(1)) | push_ok;

    m_vec_fifo #(
        .W     (N * M),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (Clk),
        .rst   (Reset),
        .push  (cap),
        .pop   (last_hs),
        .din   (Y),
        .full  (full),
        .empty (empty),
        .count (Count),
        .head  (head_v)
    );

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state <= IDLE;
            idx   <= '0;
        end else begin
            state <= state_nx;
            idx   <= idx_nx;
        end
    end

    always_comb begin
        state_nx = state;
        idx_nx   = idx;
        unique case (state)
            IDLE: begin
                if (!empty) state_nx = SEND;
            end
            SEND: begin
                if (last_hs) begin
                    idx_nx   = '0;
                    state_nx = more ? SEND : IDLE;
                end else if (hs) begin
                    idx_nx = idx + IW'(1);
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    assign OutValid = (state == SEND);
    assign OutIdx   = idx;
    assign OutLast  = (state == SEND) && (idx == IW'(M - 1));
    assign OutData  = OutValid ? head_v[idx] : '0;

    always_ff @(posedge Clk) begin
        if (Reset)                   overflow_r <= 1'b0;
        else if (cap & full & ~last_hs) overflow_r <= 1'b1;
    end
    assign Overflow = overflow_r;

`ifdef MSORTDRAIN_ORDER_CHECK_EN
    logic [M-2:0] viol;
    logic         order_err_r;

    for (genvar i = 0; i < M - 1; i++) begin : g_cmp
        assign viol[i] = (Y[i] < Y[i+1]);
    end

    always_ff @(posedge Clk) begin
        if (Reset)                 order_err_r <= 1'b0;
        else if (push_ok && |viol) order_err_r <= 1'b1;
    end
    assign OrderErr = order_err_r;
`else
    assign OrderErr = 1'b0;
`endif
endmodule

`default_nettype wire

// File: tb/tb_m_sort_drain.sv
// Randomized self-checking bench for m_sort_drain against a queue-based reference model.
`default_nettype none

module tb_m_sort_drain;
    import msort_pkg::*;

    localparam int LAT = LAT_DEF;

    logic        Clk;
    logic        Reset;
    logic        InValid;
    vec_t        Y;
    logic [N_DEF-1:0]  OutData;
    logic [IDX_W-1:0]  OutIdx;
    logic        OutValid;
    logic        OutReady;
    logic        OutLast;
    logic [CNT_W-1:0]  Count;
    logic        Overflow;
    logic        OrderErr;

    int checks = 0;
    int errors = 0;
    int edge_no = 0;

    m_sort_drain dut (
        .Clk      (Clk),
        .Reset    (Reset),
        .InValid  (InValid),
        .Y        (Y),
        .OutData  (OutData),
        .OutIdx   (OutIdx),
        .OutValid (OutValid),
        .OutReady (OutReady),
        .OutLast  (OutLast),
        .Count    (Count),
        .Overflow (Overflow),
        .OrderErr (OrderErr)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at edge %0d: got %0h expected %0h", nm, edge_no, act, exp);
        end
    endtask

    function automatic vec_t sort_desc(input vec_t x);
        vec_t  v;
        elem_t t;
        v = x;
        for (int i = 0; i < M_DEF; i++)
            for (int j = 0; j < M_DEF - 1; j++)
                if (v[j] < v[j+1]) begin
                    t = v[j]; v[j] = v[j+1]; v[j+1] = t;
                end
        return v;
    endfunction

    function automatic vec_t rand_vec();
        vec_t v;
        for (int i = 0; i < M_DEF; i++) v[i] = elem_t'((1 << $urandom_range(0, N_DEF)) - 1);
        return v;
    endfunction

    // ---------------- reference model ----------------
    vec_t yplan [int];
    vec_t mq [$];
    int   cap_t [$];
    logic m_valid = 1'b0;
    int   m_idx = 0;
    logic m_ovf = 1'b0;
    logic m_oerr = 1'b0;

    always @(posedge Clk) begin
        logic pop, cap, before_ne;
        edge_no++;
        if (Reset) begin
            mq.delete(); cap_t.delete();
            m_valid = 1'b0; m_idx = 0; m_ovf = 1'b0; m_oerr = 1'b0;
        end else begin
            pop = 1'b0;
            if (m_valid && OutReady) begin
                if (m_idx == M_DEF - 1) begin pop = 1'b1; m_idx = 0; end
                else m_idx++;
            end
            cap = (cap_t.size() != 0) && (cap_t[0] == edge_no);
            if (cap) void'(cap_t.pop_front());
            before_ne = (mq.size() != 0);
            if (pop) void'(mq.pop_front());
            if (cap) begin
                if (mq.size() < DEPTH_DEF) begin
                    mq.push_back(Y);
`ifdef MSORTDRAIN_ORDER_CHECK_EN
                    for (int i = 0; i < M_DEF - 1; i++)
                        if (Y[i] < Y[i+1]) m_oerr = 1'b1;
`endif
                end else begin
                    m_ovf = 1'b1;
                end
            end
            m_valid = m_valid ? (mq.size() != 0) : before_ne;
            if (InValid) cap_t.push_back(edge_no + LAT);
        end
    end

    always @(negedge Clk) begin
        if (edge_no > 0) begin
            check("OutValid", OutValid, m_valid);
            check("Count", Count, mq.size());
            check("Overflow", Overflow, m_ovf);
            check("OrderErr", OrderErr, m_oerr);
            check("OutIdx", OutIdx, m_valid ? m_idx : 0);
            check("OutLast", OutLast, m_valid && (m_idx == M_DEF - 1));
            check("OutData", OutData, m_valid ? mq[0][m_idx] : 0);
        end
    end

    // ---------------- stimulus ----------------
    task automatic drive(input logic iv, input vec_t x, input logic raw,
                         input logic rdy, input logic rst);
        int n;
        n = edge_no + 1;
        Reset = rst; InValid = iv; OutReady = rdy;
        if (iv) yplan[n + LAT] = raw ? x : sort_desc(x);
        Y = yplan.exists(n) ? yplan[n] : vec_t'($urandom);
        @(posedge Clk); #1;
    endtask

    task automatic idle(input logic rdy);
        drive(1'b0, '0, 1'b0, rdy, 1'b0);
    endtask

    task automatic do_reset();
        drive(1'b0, '0, 1'b0, 1'b0, 1'b1);
        drive(1'b0, '0, 1'b0, 1'b0, 1'b1);
    endtask

    initial begin
        vec_t  x0, xbad;
        elem_t exp_seq [4];
        elem_t got [$];
        int t0, guard, hs_cnt, vcnt;
        logic rdy;

        Reset = 1'b1; InValid = 1'b0; OutReady = 1'b0; Y = '0;
        x0[0] = 4'b0001; x0[1] = 4'b1111; x0[2] = 4'b0011; x0[3] = 4'b0111;
        xbad[0] = 4'b0011; xbad[1] = 4'b0111; xbad[2] = 4'b0001; xbad[3] = 4'b0000;
        exp_seq[0] = 4'b1111; exp_seq[1] = 4'b0111; exp_seq[2] = 4'b0011; exp_seq[3] = 4'b0001;

        do_reset();
        idle(1'b0);
        check("reset_count", Count, 0);
        check("reset_valid", OutValid, 0);
        check("reset_data", OutData, 0);
        check("reset_ovf", Overflow, 0);

        // single vector, latency and order
        drive(1'b1, x0, 1'b0, 1'b1, 1'b0);
        t0 = edge_no;
        guard = 0;
        while (!OutValid && guard < 20) begin idle(1'b1); guard++; end
        check("first_valid_edge", edge_no - t0, 8);
        for (int e = 0; e < 4; e++) begin
            check("single_data", OutData, exp_seq[e]);
            check("single_idx", OutIdx, e);
            check("single_last", OutLast, (e == 3));
            idle(1'b1);
        end
        check("single_count_end", Count, 0);
        check("single_valid_end", OutValid, 0);

        // backpressure with OutReady pattern 1,0,0
        drive(1'b1, x0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) idle(1'b0);
        got.delete();
        for (int s = 0; s < 40 && got.size() < 4; s++) begin
            rdy = (s % 3 == 0);
            if (OutValid && rdy) got.push_back(OutData);
            idle(rdy);
        end
        check("bp_count", got.size(), 4);
        for (int e = 0; e < 4 && e < got.size(); e++) check("bp_data", got[e], exp_seq[e]);

        // overflow
        for (int i = 0; i < 6; i++) drive(1'b1, rand_vec(), 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) idle(1'b0);
        check("ovf_count", Count, 4);
        check("ovf_flag", Overflow, 1);
        hs_cnt = 0;
        for (int i = 0; i < 30; i++) begin
            if (OutValid) hs_cnt++;
            idle(1'b1);
        end
        check("ovf_emitted", hs_cnt, 16);

        // full with simultaneous pop
        do_reset();
        for (int i = 0; i < 4; i++) drive(1'b1, rand_vec(), 1'b0, 1'b0, 1'b0);
        guard = 0;
        while (!(OutValid && Count == 4) && guard < 20) begin idle(1'b0); guard++; end
        check("fp_full", Count, 4);
        drive(1'b1, rand_vec(), 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) idle(1'b0);
        for (int i = 0; i < 4; i++) idle(1'b1);
        check("fp_count", Count, 4);
        check("fp_ovf", Overflow, 0);
        for (int i = 0; i < 25; i++) idle(1'b1);
        check("fp_drained", Count, 0);

        // reset mid-stream
        drive(1'b1, rand_vec(), 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) idle(1'b1);
        drive(1'b1, rand_vec(), 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) idle(1'b1);
        check("rst_mid_idx", OutIdx, 2);
        drive(1'b0, '0, 1'b0, 1'b1, 1'b1);
        check("rst_mid_valid", OutValid, 0);
        check("rst_mid_count", Count, 0);
        vcnt = 0;
        for (int i = 0; i < 20; i++) begin
            if (OutValid) vcnt++;
            idle(1'b1);
        end
        check("rst_mid_silent", vcnt, 0);

        // order check
        drive(1'b1, xbad, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < LAT - 1; i++) idle(1'b1);
        check("oerr_before", OrderErr, 0);
        idle(1'b1);
`ifdef MSORTDRAIN_ORDER_CHECK_EN
        check("oerr_set", OrderErr, 1);
        for (int i = 0; i < 10; i++) idle(1'b1);
        check("oerr_held", OrderErr, 1);
`else
        check("oerr_off", OrderErr, 0);
        for (int i = 0; i < 10; i++) idle(1'b1);
        check("oerr_off_held", OrderErr, 0);
`endif
        do_reset();
        check("oerr_cleared", OrderErr, 0);

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            drive(($urandom_range(0, 2) == 0), rand_vec(), ($urandom_range(0, 19) == 0),
                  ($urandom_range(0, 3) != 0), ($urandom_range(0, 199) == 0));
        end
        for (int i = 0; i < 40; i++) idle(1'b1);
        check("final_drained", Count, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

`default_nettype wire

// File: doc/m_sort_drain.md
# m_sort_drain

Receive end of the wide sorter's output interface. Tracks sorter pipeline latency with a valid shift chain and captures each sorted M-element vector into a small vector FIFO. Streams vectors out one element per handshake over valid/ready, largest element first. Sits between the systolic sorter and any narrow downstream consumer; the sorter itself carries no valid or backpressure.

## Interface
- N, 4, element width in bits (thermometer-coded values, same as the sorter)
- M, 4, elements per vector
- LAT, 2*M-1, sorter latency in cycles from X sampled to Y valid
- DEPTH, 4, FIFO depth in vectors; power of 2, ≥2
- Clk  in  1  clock; single clock domain
- Reset  in  1  synchronous, active-high
- InValid  in  1  high in the cycle a vector is presented on the sorter's X
- Y  in  N × [M-1:0]  sorter outputs; Y[0] largest, Y[M-1] smallest
- OutData  out  N  current element
- OutIdx  out  $clog2(M)  element index within vector, 0 = largest
- OutValid  out  1  OutData/OutIdx/OutLast valid
- OutReady  in  1  consumer accepts when OutValid & OutReady
- OutLast  out  1  high with element M-1
- Count  out  $clog2(DEPTH)+1  vectors held, including the one streaming
- Overflow  out  1  sticky: a vector was dropped
- OrderErr  out  1  sticky: a captured vector was not non-increasing

## Operation
- Valid chain: LAT-deep shift register of InValid. The tap (Cap) marks the cycle in which Y holds that vector's result.
- Capture: on Cap, write Y[0..M-1] into FIFO entry wr_ptr and increment Count.
  - If the FIFO is full and no pop occurs in that cycle, drop the vector and set Overflow.
  - If the FIFO is full and a pop occurs in that cycle, accept the vector. The freed slot is reused the same cycle.
- Serializer FSM:
  - IDLE → SEND when Count≠0.
  - In SEND: OutData = mem[rd_ptr][idx], OutIdx = idx, OutValid = 1.
  - On handshake with idx<M-1: idx increments.
  - On handshake with idx=M-1: pop (rd_ptr++, Count--) and idx→0. Stay in SEND if another vector remains (back-to-back, no bubble), else → IDLE.
- Elements are not accepted out of order. A stalled OutReady holds OutData, OutIdx and OutLast stable.
- Pointers wrap modulo DEPTH.
- Push and pop in the same cycle leave Count unchanged.
- Reset mid-stream:
  - Clears the valid chain, pointers, Count, idx and state.
  - Clears Overflow and OrderErr.
  - In-flight sorter results whose InValid preceded reset are never captured.
- Reset values: OutValid=0, OutLast=0, OutIdx=0, OutData=0, Count=0, Overflow=0, OrderErr=0.

## Timing
- InValid sampled at edge t → Y captured at edge t+LAT → OutValid high from cycle t+LAT+1 (when the FIFO was empty and the FSM idle).
- OutValid, OutIdx, OutLast and Count are registered. OutData is a mux of registered FIFO storage indexed by registered pointers; no input-to-output combinational path.
- Steady-state throughput is one element per cycle, i.e. one vector per M cycles. The sorter may accept one vector per cycle, so sustained InValid density above 1/M overflows after DEPTH vectors of slack.

## Configuration
- MSORTDRAIN_ORDER_CHECK_EN defined:
  - On each accepted capture, compare Y[i] ≥ Y[i+1] for all i as unsigned values.
  - Any violation sets OrderErr the cycle after capture; it stays set until Reset.
- Undefined: no comparators are built and OrderErr is tied 0.

## Structure
- Shared package msort_pkg holds:
  - elem_t (logic [N-1:0]) and vec_t (elem_t [M-1:0]);
  - localparams for the LAT default (2*M-1) and the $clog2 widths;
  - state enum {IDLE, SEND}.
- One sub-module: m_vec_fifo, a parameterised DEPTH × vec_t synchronous FIFO with push, pop, full, empty, count and head output.
- The valid chain and serializer FSM live in the top.

## Test plan
- Single vector, M=4, N=4: X={0001,1111,0011,0111}, InValid 1 cycle, OutReady=1 → OutValid rises 8 cycles after InValid (LAT=7). OutData sequence 1111,0111,0011,0001 with OutIdx 0..3. OutLast only on 0001. Count returns to 0.
- Backpressure: same vector, OutReady toggling 1,0,0,1,… → each element held stable while stalled; sequence unchanged; no duplicates.
- Overflow: InValid high 6 consecutive cycles, OutReady=0 → Count saturates at 4 and Overflow=1. Then OutReady=1 → exactly 16 elements emitted, from the first 4 vectors.
- Full plus simultaneous pop: FIFO full and a capture coincides with the OutLast handshake → vector accepted, Count stays 4, Overflow stays 0.
- Reset mid-stream: Reset at element 2 of vector 1 with vector 2 in the valid chain → next cycle OutValid=0 and Count=0. Nothing is emitted afterwards without new InValid.
- With MSORTDRAIN_ORDER_CHECK_EN: force Y={0011,0111,0001,0000} on Cap → OrderErr=1 the next cycle and held until Reset. Without the macro, OrderErr stays 0.
